verin_position_ctrl: RTL and testbench

Closed-loop position sequencer for the tiller actuator (vérin). The block periodically acquires the actuator position from the 12-bit serial ADC and compares it with a software setpoint clamped to the end stops. It then drives the enable and direction inputs of the existing PWM stage. It sits between the Avalon register slave and the exported ADC/PWM pins, replacing software polling of the ADC.

---
 rtl/verin_pkg.sv | 23 ++
 rtl/verin_adc_rx.sv | 92 +++++++++
 rtl/verin_position_ctrl.sv | 155 +++++++++++++++
 tb/tb_verin_position_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verin_pkg.sv
// Shared constants, FSM state type and target clamp for the tiller actuator
// position controller.
package verin_pkg;

  localparam int unsigned ADC_W        = 12;
  localparam int unsigned FRAME_BITS   = 15;
  localparam int unsigned DISCARD_BITS = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    EVAL
  } state_e;

  function automatic logic [ADC_W-1:0] clamp(input logic [ADC_W-1:0] v,
                                             input logic [ADC_W-1:0] lo,
                                             input logic [ADC_W-1:0] hi);
    logic [ADC_W-1:0] t;
    t = (v < lo) ? lo : v;
    return (t > hi) ? hi : t;
  endfunction

endpackage

// File: rtl/verin_adc_rx.sv
// Serial ADC frame receiver: generates cs_n/clk_1m for one 15-bit frame and
// shifts in the 12 result bits that follow the 3 leading discard bits.
module verin_adc_rx
  import verin_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             data_in,
  output logic             clk_1m,
  output logic             cs_n,
  output logic [ADC_W-1:0] data,
  output logic             done
);

  localparam int unsigned DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned HALF_W = $clog2(2 * FRAME_BITS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(2 * FRAME_BITS - 1);
  localparam logic [HALF_W-1:0] FIRST_KEEP = HALF_W'(2 * DISCARD_BITS);

  logic              active_q, active_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              clk_1m_q, clk_1m_d;
  logic              cs_n_q, cs_n_d;
  logic [ADC_W-1:0]  shreg_q, shreg_d;
  logic              done_q, done_d;

  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    half_d   = half_q;
    clk_1m_d = clk_1m_q;
    cs_n_d   = cs_n_q;
    shreg_d  = shreg_q;
    done_d   = 1'b0;
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        cs_n_d   = 1'b0;
        div_d    = '0;
        half_d   = '0;
        clk_1m_d = 1'b0;
      end
    end else if (div_q == DIV_LAST) begin
      div_d    = '0;
      clk_1m_d = !clk_1m_q;
      half_d   = half_q + 1'b1;
      // Sample on the edge that drives clk_1m high; early bits are dropped.
      if (!clk_1m_q && (half_q >= FIRST_KEEP)) begin
        shreg_d = {shreg_q[ADC_W-2:0], data_in};
      end
      if (half_q == HALF_LAST) begin
        active_d = 1'b0;
        cs_n_d   = 1'b1;
        clk_1m_d = 1'b0;
        done_d   = 1'b1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      div_q    <= '0;
      half_q   <= '0;
      clk_1m_q <= 1'b0;
      cs_n_q   <= 1'b1;
      shreg_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      half_q   <= half_d;
      clk_1m_q <= clk_1m_d;
      cs_n_q   <= cs_n_d;
      shreg_q  <= shreg_d;
      done_q   <= done_d;
    end
  end

  assign clk_1m = clk_1m_q;
  assign cs_n   = cs_n_q;
  assign data   = shreg_q;
  assign done   = done_q;

endmodule

// File: rtl/verin_position_ctrl.sv
// Closed-loop tiller actuator sequencer: periodic ADC acquisition, clamped
// setpoint comparison, PWM enable/direction drive and sticky stall fault.
module verin_position_ctrl
  import verin_pkg::*;
#(
  parameter int unsigned PERIOD_CYC    = 5_000_000,
  parameter int unsigned SCLK_DIV      = 25,
  parameter int unsigned DEADBAND      = 8,
  parameter int unsigned STALL_SAMPLES = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] setpoint,
  input  logic [11:0] butee_min,
  input  logic [11:0] butee_max,
  input  logic        fault_clr,
  input  logic        data_in,
  output logic        clk_1m,
  output logic        cs_n,
  output logic [11:0] position,
  output logic        pos_valid,
  output logic        pwm_en,
  output logic        sens,
  output logic        at_target,
  output logic        fault
);

  localparam int unsigned PER_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int unsigned ST_W  = $clog2(STALL_SAMPLES + 1);

  state_e            state_q, state_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic [ADC_W-1:0]  position_q, position_d;
  logic              pos_valid_q, pos_valid_d;
  logic              pwm_en_q, pwm_en_d;
  logic              sens_q, sens_d;
  logic              at_target_q, at_target_d;
  logic              fault_q, fault_d;
  logic [ST_W-1:0]   stall_q, stall_d;
  logic [ADC_W:0]    prev_abs_q, prev_abs_d;

  logic              tc, adc_start, adc_done;
  logic [ADC_W-1:0]  adc_data, tgt;
  logic [ADC_W:0]    err, abs_err;
  logic              in_db, cfg_ok, allow;

  assign tc        = (per_q == PER_W'(PERIOD_CYC - 1));
  assign adc_start = (state_q == IDLE) && tc;

  verin_adc_rx #(.SCLK_DIV(SCLK_DIV)) u_adc (
    .clk     (clk),
    .reset   (reset),
    .start   (adc_start),
    .data_in (data_in),
    .clk_1m  (clk_1m),
    .cs_n    (cs_n),
    .data    (adc_data),
    .done    (adc_done)
  );

  always_comb begin
    tgt     = clamp(setpoint, butee_min, butee_max);
    err     = {1'b0, tgt} - {1'b0, position_q};
    abs_err = err[ADC_W] ? (~err + 1'b1) : err;
    in_db   = (abs_err <= (ADC_W+1)'(DEADBAND));
    cfg_ok  = (butee_min <= butee_max);
    allow   = enable && !fault_q && cfg_ok && !in_db;
  end

  always_comb begin
    logic [ST_W-1:0] cnt;
    logic            set_fault;
    state_d     = state_q;
    per_d       = tc ? '0 : per_q + 1'b1;
    position_d  = adc_done ? adc_data : position_q;
    pos_valid_d = adc_done;
    pwm_en_d    = pwm_en_q;
    sens_d      = sens_q;
    at_target_d = at_target_q;
    fault_d     = fault_q;
    stall_d     = stall_q;
    prev_abs_d  = prev_abs_q;
    cnt         = '0;
    set_fault   = 1'b0;

    case (state_q)
      IDLE:    if (tc) state_d = ACQ;
      ACQ:     if (adc_done) state_d = EVAL;
      EVAL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == EVAL) begin
      at_target_d = in_db;
      prev_abs_d  = abs_err;
      if (allow) begin
        // No progress means |err| failed to shrink by at least one LSB.
        cnt = (abs_err >= prev_abs_q) ? stall_q + 1'b1 : '0;
        if (cnt == ST_W'(STALL_SAMPLES)) begin
          set_fault = 1'b1;
          fault_d   = 1'b1;
          pwm_en_d  = 1'b0;
          stall_d   = '0;
        end else begin
          pwm_en_d = 1'b1;
          sens_d   = !err[ADC_W];
          stall_d  = cnt;
        end
      end else begin
        pwm_en_d = 1'b0;
        stall_d  = '0;
      end
    end

    if (fault_clr && !set_fault) begin
      fault_d = 1'b0;
      stall_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      per_q       <= '0;
      position_q  <= '0;
      pos_valid_q <= 1'b0;
      pwm_en_q    <= 1'b0;
      sens_q      <= 1'b0;
      at_target_q <= 1'b0;
      fault_q     <= 1'b0;
      stall_q     <= '0;
      prev_abs_q  <= '0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      position_q  <= position_d;
      pos_valid_q <= pos_valid_d;
      pwm_en_q    <= pwm_en_d;
      sens_q      <= sens_d;
      at_target_q <= at_target_d;
      fault_q     <= fault_d;
      stall_q     <= stall_d;
      prev_abs_q  <= prev_abs_d;
    end
  end

  assign position  = position_q;
  assign pos_valid = pos_valid_q;
  assign pwm_en    = pwm_en_q;
  assign sens      = sens_q;
  assign at_target = at_target_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_verin_position_ctrl.sv
// Bench for verin_position_ctrl: cycle-arithmetic reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_verin_position_ctrl;

  localparam int PER  = 200;
  localparam int DIV  = 2;
  localparam int DB   = 8;
  localparam int STALL = 3;
  localparam int CS_LOW = 30 * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [11:0] setpoint = 12'h600;
  logic [11:0] butee_min = 12'h000;
  logic [11:0] butee_max = 12'hFFF;
  logic        fault_clr = 1'b0;
  logic        data_in = 1'b0;
  logic        clk_1m, cs_n, pos_valid, pwm_en, sens, at_target, fault;
  logic [11:0] position;

  logic [11:0] adc_val = 12'h5A3;
  logic [14:0] adc_word = '0;
  int          adc_bit = 0;
  int          adc_edges = 0;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;
  int cyc = 0;

  int          m_n = 0;
  logic [11:0] m_pos = '0, m_frame = '0;
  bit          m_pv, m_pwm, m_sens, m_at, m_fault, m_cs = 1'b1, m_clk;
  int          m_stall = 0, m_prev = 0;

  verin_position_ctrl #(
    .PERIOD_CYC    (PER),
    .SCLK_DIV      (DIV),
    .DEADBAND      (DB),
    .STALL_SAMPLES (STALL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .setpoint  (setpoint),
    .butee_min (butee_min),
    .butee_max (butee_max),
    .fault_clr (fault_clr),
    .data_in   (data_in),
    .clk_1m    (clk_1m),
    .cs_n      (cs_n),
    .position  (position),
    .pos_valid (pos_valid),
    .pwm_en    (pwm_en),
    .sens      (sens),
    .at_target (at_target),
    .fault     (fault)
  );

  always #5 clk = !clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ADC device: first bit out at cs_n fall, next bit after each clk_1m rise.
  initial forever begin
    @(negedge cs_n or posedge clk_1m);
    if (clk_1m === 1'b1) begin
      if (cs_n === 1'b0) begin
        adc_edges++;
        adc_bit++;
        if (adc_bit < 15) data_in = adc_word[14 - adc_bit];
      end
    end else begin
      adc_word  = {3'b111, adc_val};
      adc_bit   = 0;
      adc_edges = 0;
      data_in   = adc_word[14];
    end
  end

  initial forever begin
    @(posedge cs_n);
    if (cmp_on && !reset) chk("clk_1m_rising_edges", adc_edges, 15);
  end

  // Reference model: frame k starts PER*k edges after reset release.
  initial forever begin
    int p, tgt, err, a;
    bit fr, set;
    @(posedge clk);
    cyc++;
    set = 1'b0;
    if (reset) begin
      m_n = 0; m_pos = '0; m_pv = 0; m_pwm = 0; m_sens = 0; m_at = 0;
      m_fault = 0; m_stall = 0; m_prev = 0;
    end else begin
      m_n++;
      p  = m_n % PER;
      fr = (m_n >= PER);
      if (fr && p == 0) m_frame = adc_val;
      m_pv = fr && (p == CS_LOW + 1);
      if (m_pv) m_pos = m_frame;
      if (fr && p == CS_LOW + 2) begin
        tgt = (setpoint < butee_min) ? int'(butee_min) : int'(setpoint);
        if (tgt > int'(butee_max)) tgt = int'(butee_max);
        err = tgt - int'(m_pos);
        a   = (err < 0) ? -err : err;
        m_at = (a <= DB);
        if (enable && !m_fault && (butee_min <= butee_max) && !m_at) begin
          m_stall = (a >= m_prev) ? m_stall + 1 : 0;
          if (m_stall >= STALL) begin
            set = 1'b1; m_fault = 1; m_pwm = 0; m_stall = 0;
          end else begin
            m_pwm = 1; m_sens = (err > 0);
          end
        end else begin
          m_pwm = 0; m_stall = 0;
        end
        m_prev = a;
      end
      if (fault_clr && !set) begin
        m_fault = 0; m_stall = 0;
      end
    end
    p = m_n % PER;
    m_cs  = !(m_n >= PER && p < CS_LOW);
    m_clk = (m_n >= PER && p < CS_LOW && ((p / DIV) % 2 == 1));
  end

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      chk("cs_n", cs_n, m_cs);
      chk("clk_1m", clk_1m, m_clk);
      chk("pos_valid", pos_valid, m_pv);
      chk("position", position, m_pos);
      chk("pwm_en", pwm_en, m_pwm);
      chk("sens", sens, m_sens);
      chk("at_target", at_target, m_at);
      chk("fault", fault, m_fault);
    end
  end

  int pv_cycle = 0;

  // Waits through one acquisition; returns at the negedge after drive update.
  task automatic wait_drive(input bit clr_in_eval);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * PER + 50; i++) begin
      @(negedge clk);
      if (cs_n === 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) begin chk("timeout_cs_fall", 0, 1); return; end
    ok = 1'b0;
    for (int i = 0; i < CS_LOW + 20; i++) begin
      @(negedge clk);
      if (cs_n === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin chk("timeout_cs_rise", 0, 1); return; end
    @(negedge clk);
    chk("pos_valid_after_cs_rise", pos_valid, 1'b1);
    pv_cycle = cyc;
    if (clr_in_eval) fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  initial begin
    int pv_prev;
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_clk_1m", clk_1m, 1'b0);
    chk("rst_position", position, 12'h000);
    chk("rst_pwm_en", pwm_en, 1'b0);
    chk("rst_fault", fault, 1'b0);
    cmp_on = 1'b1;
    reset  = 1'b0;

    wait_drive(1'b0);
    chk("f1_position", position, 12'h5A3);
    chk("f1_pwm_en", pwm_en, 1'b1);
    chk("f1_sens", sens, 1'b1);
    chk("f1_at_target", at_target, 1'b0);

    setpoint = 12'h5A0;
    wait_drive(1'b0);
    chk("db3_pwm_en", pwm_en, 1'b0);
    chk("db3_at_target", at_target, 1'b1);

    setpoint = 12'h5AB;
    wait_drive(1'b0);
    chk("db8_at_target", at_target, 1'b1);

    setpoint = 12'h5AC;
    wait_drive(1'b0);
    chk("db9_pwm_en", pwm_en, 1'b1);
    chk("db9_sens", sens, 1'b1);
    chk("db9_at_target", at_target, 1'b0);

    setpoint = 12'hF00; butee_max = 12'h800; adc_val = 12'h800;
    wait_drive(1'b0);
    chk("clamp_at_target", at_target, 1'b1);
    chk("clamp_pwm_en", pwm_en, 1'b0);

    butee_min = 12'h900; adc_val = 12'h100;
    wait_drive(1'b0);
    chk("badcfg_position", position, 12'h100);
    chk("badcfg_pwm_en", pwm_en, 1'b0);
    chk("badcfg_fault", fault, 1'b0);

    butee_min = 12'h000; butee_max = 12'hFFF; setpoint = 12'h100;
    wait_drive(1'b0);
    chk("prestall_at_target", at_target, 1'b1);

    setpoint = 12'h400;
    wait_drive(1'b0);
    chk("stall1_pwm_en", pwm_en, 1'b1);
    chk("stall1_fault", fault, 1'b0);
    wait_drive(1'b0);
    chk("stall2_pwm_en", pwm_en, 1'b1);
    wait_drive(1'b0);
    chk("stall3_fault", fault, 1'b1);
    chk("stall3_pwm_en", pwm_en, 1'b0);

    pulse_clr();
    chk("clr_fault", fault, 1'b0);
    wait_drive(1'b0);
    chk("restall1_pwm_en", pwm_en, 1'b1);
    wait_drive(1'b0);
    chk("restall2_fault", fault, 1'b0);
    wait_drive(1'b1);
    chk("setwins_fault", fault, 1'b1);
    chk("setwins_pwm_en", pwm_en, 1'b0);
    pulse_clr();
    chk("clr2_fault", fault, 1'b0);

    ok = 1'b0;
    for (int i = 0; i < 2 * PER + 50; i++) begin
      @(negedge clk);
      if (cs_n === 1'b0 && adc_edges == 7) begin ok = 1'b1; break; end
    end
    if (!ok) chk("timeout_edge7", 0, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_cs_n", cs_n, 1'b1);
    chk("midrst_clk_1m", clk_1m, 1'b0);
    chk("midrst_pos_valid", pos_valid, 1'b0);
    chk("midrst_position", position, 12'h000);
    chk("midrst_sens", sens, 1'b0);
    reset = 1'b0;
    wait_drive(1'b0);
    chk("postrst_position", position, 12'h100);
    chk("postrst_pwm_en", pwm_en, 1'b1);

    enable = 1'b0;
    wait_drive(1'b0);
    chk("dis1_pwm_en", pwm_en, 1'b0);
    pv_prev = pv_cycle;
    wait_drive(1'b0);
    chk("dis2_pwm_en", pwm_en, 1'b0);
    chk("dis_pv_interval", pv_cycle - pv_prev, PER);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
